// File: rtl/pe_pkg.sv
// Shared definitions for the PE feed sequencer: operand geometry,
// accumulator count, pass-count width, drain watchdog limit and FSM states.
package pe_pkg;

    localparam int INT_BITS  = 7;
    localparam int FRAC_BITS = 9;
    localparam int W         = INT_BITS + FRAC_BITS;
    localparam int NUM_ACC   = 8;
    localparam int K_W       = 8;
    localparam int DRAIN_TO  = 16;
    localparam int IDX_W     = $clog2(NUM_ACC);
    localparam int ADD_W     = 4;
    localparam int DCNT_W    = $clog2(DRAIN_TO + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        CLEAR = 2'd3
    } feed_state_t;

    // Index of the final pass; a requested pass count of zero runs one pass.
    function automatic logic [K_W-1:0] calc_k_last(input logic [K_W-1:0] k);
        logic [K_W-1:0] r;
        if (k == {K_W{1'b0}}) begin
            r = {K_W{1'b0}};
        end else begin
            r = k - K_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/pe_feed_idx_ctr.sv
// Accumulator index / pass counter pair. The index walks 0..NUM_ACC-1 and
// the pass count steps each time the index wraps. Flags mark the final pass
// and the final beat of the tile.
module pe_feed_idx_ctr
    import pe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic [K_W-1:0]   k_last,
    output logic [IDX_W-1:0] idx,
    output logic             last_pass,
    output logic             last_beat
);

    logic [IDX_W-1:0] idx_r;
    logic [K_W-1:0]   pass_r;
    logic             idx_wrap_s;

    assign idx_wrap_s = (idx_r == IDX_W'(NUM_ACC - 1));
    assign idx        = idx_r;
    assign last_pass  = (pass_r == k_last);
    assign last_beat  = last_pass && idx_wrap_s;

    // Advance the index on each accepted beat; bump the pass on wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r  <= {IDX_W{1'b0}};
            pass_r <= {K_W{1'b0}};
        end else if (clr) begin
            idx_r  <= {IDX_W{1'b0}};
            pass_r <= {K_W{1'b0}};
        end else if (adv) begin
            if (idx_wrap_s) begin
                idx_r  <= {IDX_W{1'b0}};
                pass_r <= pass_r + K_W'(1);
            end else begin
                idx_r  <= idx_r + IDX_W'(1);
                pass_r <= pass_r;
            end
        end else begin
            idx_r  <= idx_r;
            pass_r <= pass_r;
        end
    end

endmodule

// File: rtl/pe_feed_seq.sv
// Upstream sequencer for one PE. Streams operand pairs into the PE as
// cfg_k passes over NUM_ACC interleaved accumulators, rounding on the final
// pass, then drains with zero operands until the PE reports its last rounded
// result, pulses the PE reset for one cycle and returns to idle.
// Optional build macro PE_FEED_TIMEOUT_EN adds a drain watchdog that raises
// a sticky err and forces the clear when the PE never answers.
module pe_feed_seq
    import pe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [K_W-1:0]   cfg_k,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_a,
    input  logic [W-1:0]     s_b,
    output logic [W-1:0]     pe_data_in_1,
    output logic [W-1:0]     pe_data_in_2,
    output logic [ADD_W-1:0] pe_add_number,
    output logic             pe_rounder_en,
    output logic             pe_keep,
    output logic             pe_rst_n,
    input  logic             pe_rounder_valid
);

    feed_state_t      state_r;
    feed_state_t      state_s;
    logic [K_W-1:0]   k_last_r;
    logic             accept_s;
    logic             launch_s;
    logic             ctr_clr_s;
    logic             timeout_s;
    logic [IDX_W-1:0] idx_s;
    logic             last_pass_s;
    logic             last_beat_s;

    logic             busy_r;
    logic             done_r;
    logic             s_ready_r;
    logic             pe_rst_n_r;
    logic [W-1:0]     d1_r;
    logic [W-1:0]     d2_r;
    logic [ADD_W-1:0] add_r;
    logic             ren_r;
    logic             keep_r;

    // Handshake is decided from the state register only, so s_valid never
    // reaches s_ready combinationally.
    assign accept_s  = s_valid && (state_r == RUN);
    assign launch_s  = start && (state_r == IDLE);
    assign ctr_clr_s = launch_s || (state_r == CLEAR);

    pe_feed_idx_ctr u_idx_ctr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (ctr_clr_s),
        .adv       (accept_s),
        .k_last    (k_last_r),
        .idx       (idx_s),
        .last_pass (last_pass_s),
        .last_beat (last_beat_s)
    );

`ifdef PE_FEED_TIMEOUT_EN
    logic [DCNT_W-1:0] drain_cnt_r;
    logic              err_r;

    assign timeout_s = (drain_cnt_r == DCNT_W'(DRAIN_TO - 1));
    assign err       = err_r;

    // Count cycles spent waiting in DRAIN; restart from zero outside it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drain_cnt_r <= {DCNT_W{1'b0}};
        end else if (state_r == DRAIN) begin
            drain_cnt_r <= drain_cnt_r + DCNT_W'(1);
        end else begin
            drain_cnt_r <= {DCNT_W{1'b0}};
        end
    end

    // Sticky watchdog error, cleared when a new tile is launched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_r <= 1'b0;
        end else if (launch_s) begin
            err_r <= 1'b0;
        end else if ((state_r == DRAIN) && !pe_rounder_valid && timeout_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end
`else
    assign timeout_s = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state decode for the tile sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (accept_s && last_beat_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (pe_rounder_valid || timeout_s) begin
                    state_s = CLEAR;
                end else begin
                    state_s = DRAIN;
                end
            end
            CLEAR: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Latch the final-pass index when a tile is launched.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            k_last_r <= {K_W{1'b0}};
        end else if (launch_s) begin
            k_last_r <= calc_k_last(cfg_k);
        end else begin
            k_last_r <= k_last_r;
        end
    end

    // Status and PE reset outputs, registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            s_ready_r  <= 1'b0;
            done_r     <= 1'b0;
            pe_rst_n_r <= 1'b0;
        end else begin
            busy_r     <= (state_s != IDLE);
            s_ready_r  <= (state_s == RUN);
            done_r     <= (state_r == CLEAR);
            pe_rst_n_r <= (state_s != CLEAR);
        end
    end

    // Operand, index and control registers driven into the PE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d1_r   <= {W{1'b0}};
            d2_r   <= {W{1'b0}};
            add_r  <= {ADD_W{1'b0}};
            ren_r  <= 1'b0;
            keep_r <= 1'b1;
        end else begin
            case (state_r)
                RUN: begin
                    if (accept_s) begin
                        d1_r   <= s_a;
                        d2_r   <= s_b;
                        add_r  <= ADD_W'(idx_s);
                        ren_r  <= last_pass_s;
                        keep_r <= 1'b0;
                    end else begin
                        ren_r  <= 1'b0;
                        keep_r <= 1'b1;
                    end
                end
                DRAIN: begin
                    // Zero operands keep the PE pipeline moving without
                    // disturbing the accumulators.
                    d1_r   <= {W{1'b0}};
                    d2_r   <= {W{1'b0}};
                    ren_r  <= 1'b0;
                    keep_r <= 1'b0;
                end
                default: begin
                    ren_r  <= 1'b0;
                    keep_r <= 1'b1;
                end
            endcase
        end
    end

    assign busy          = busy_r;
    assign s_ready       = s_ready_r;
    assign done          = done_r;
    assign pe_rst_n      = pe_rst_n_r;
    assign pe_data_in_1  = d1_r;
    assign pe_data_in_2  = d2_r;
    assign pe_add_number = add_r;
    assign pe_rounder_en = ren_r;
    assign pe_keep       = keep_r;

endmodule

// File: tb/tb_pe_feed_seq.sv
// Bench for pe_feed_seq: a beat-count model of the tile sequence checked
// against every DUT output each cycle, plus hand-computed tile timings.
// Honours PE_FEED_TIMEOUT_EN for the watchdog scenario.
module tb_pe_feed_seq;

    localparam int NUM_ACC  = 8;
    localparam int DRAIN_TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_k;
    logic        busy;
    logic        done;
    logic        err;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_a;
    logic [15:0] s_b;
    logic [15:0] pe_data_in_1;
    logic [15:0] pe_data_in_2;
    logic [3:0]  pe_add_number;
    logic        pe_rounder_en;
    logic        pe_keep;
    logic        pe_rst_n;
    logic        pe_rounder_valid;

    int checks = 0;
    int errors = 0;

    pe_feed_seq dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .cfg_k            (cfg_k),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_a              (s_a),
        .s_b              (s_b),
        .pe_data_in_1     (pe_data_in_1),
        .pe_data_in_2     (pe_data_in_2),
        .pe_add_number    (pe_add_number),
        .pe_rounder_en    (pe_rounder_en),
        .pe_keep          (pe_keep),
        .pe_rst_n         (pe_rst_n),
        .pe_rounder_valid (pe_rounder_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 streaming, 2 draining, 3 clearing
    int          m_phase = 0;
    int          m_beats = 0;
    int          m_k = 1;
    int          m_dcnt = 0;
    int          m_add = 0;
    logic        m_err = 1'b0;
    logic        m_done = 1'b0;
    logic        m_in_reset = 1'b1;
    logic        m_ren = 1'b0;
    logic        m_keep = 1'b1;
    logic [15:0] m_d1 = 16'h0000;
    logic [15:0] m_d2 = 16'h0000;
    logic        model_ok = 1'b0;
    int          cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_phase    <= 0;
            m_beats    <= 0;
            m_k        <= 1;
            m_dcnt     <= 0;
            m_add      <= 0;
            m_err      <= 1'b0;
            m_done     <= 1'b0;
            m_in_reset <= 1'b1;
            m_ren      <= 1'b0;
            m_keep     <= 1'b1;
            m_d1       <= 16'h0000;
            m_d2       <= 16'h0000;
            model_ok   <= 1'b1;
        end else begin
            m_in_reset <= 1'b0;
            m_done     <= (m_phase == 3);
            case (m_phase)
                0: begin
                    m_keep <= 1'b1;
                    m_ren  <= 1'b0;
                    if (start) begin
                        m_k     <= (cfg_k == 8'd0) ? 1 : int'(cfg_k);
                        m_err   <= 1'b0;
                        m_beats <= 0;
                        m_phase <= 1;
                    end
                end
                1: begin
                    if (s_valid) begin
                        m_d1    <= s_a;
                        m_d2    <= s_b;
                        m_add   <= m_beats % NUM_ACC;
                        m_ren   <= ((m_beats / NUM_ACC) == (m_k - 1));
                        m_keep  <= 1'b0;
                        m_beats <= m_beats + 1;
                        if (m_beats + 1 == NUM_ACC * m_k) begin
                            m_phase <= 2;
                            m_dcnt  <= 0;
                        end
                    end else begin
                        m_keep <= 1'b1;
                        m_ren  <= 1'b0;
                    end
                end
                2: begin
                    m_keep <= 1'b0;
                    m_ren  <= 1'b0;
                    m_d1   <= 16'h0000;
                    m_d2   <= 16'h0000;
                    if (pe_rounder_valid) begin
                        m_phase <= 3;
                    end else begin
                        m_dcnt <= m_dcnt + 1;
`ifdef PE_FEED_TIMEOUT_EN
                        if (m_dcnt + 1 == DRAIN_TO) begin
                            m_err   <= 1'b1;
                            m_phase <= 3;
                        end
`endif
                    end
                end
                default: begin
                    m_keep  <= 1'b1;
                    m_ren   <= 1'b0;
                    m_phase <= 0;
                end
            endcase
        end
    end

    // ---------------- per-cycle compare and statistics ----------------
    int ren_seen = 0;
    int keep_run = 0;
    int prst_low = 0;
    int done_cyc = 0;

    always @(negedge clk) begin
        if (model_ok) begin
            check("busy",      busy,          (m_phase != 0));
            check("s_ready",   s_ready,       (m_phase == 1));
            check("done",      done,          m_done);
            check("err",       err,           m_err);
            check("pe_rst_n",  pe_rst_n,      (!m_in_reset && m_phase != 3));
            check("pe_keep",   pe_keep,       m_keep);
            check("pe_ren",    pe_rounder_en, m_ren);
            check("pe_add",    pe_add_number, m_add);
            check("pe_data_1", pe_data_in_1,  m_d1);
            check("pe_data_2", pe_data_in_2,  m_d2);
        end
        if (pe_rounder_en === 1'b1) ren_seen <= ren_seen + 1;
        if (pe_keep === 1'b1 && m_phase == 1 && m_beats > 0) keep_run <= keep_run + 1;
        if (pe_rst_n === 1'b0 && rst_n) prst_low <= prst_low + 1;
        if (done === 1'b1) done_cyc <= cyc;
    end

    // ---------------- stimulus ----------------
    int t0;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_phase(input int p, input int limit);
        int n = 0;
        while (m_phase != p && n < limit) begin
            step();
            n++;
        end
        check("wait_phase", m_phase, p);
    endtask

    task automatic start_tile(input logic [7:0] k);
        cfg_k = k;
        start = 1'b1;
        t0    = cyc;
        step();
        start = 1'b0;
        cfg_k = 8'hFF;
    endtask

    task automatic feed(input int n, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] inc, input int stall_at, input int stall_len,
                        input int start_at);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            if (i == stall_at) begin
                s_valid = 1'b0;
                repeat (stall_len) step();
            end
            while (!s_ready && w < 20) begin
                s_valid = 1'b0;
                step();
                w++;
            end
            check("s_ready_wait", s_ready, 1'b1);
            s_valid = 1'b1;
            s_a     = a + 16'(i) * inc;
            s_b     = b - 16'(i) * inc;
            start   = (i == start_at);
            step();
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic drain_finish(input int delay);
        wait_phase(2, 40);
        repeat (delay) step();
        pe_rounder_valid = 1'b1;
        step();
        pe_rounder_valid = 1'b0;
        wait_phase(0, 10);
        step();
        step();
    endtask

    initial begin
        int r0, k0, p0;
        rst_n = 1'b0; start = 1'b0; cfg_k = 8'd0; s_valid = 1'b0;
        s_a = 16'h0000; s_b = 16'h0000; pe_rounder_valid = 1'b0;
        repeat (3) step();
        check("rst_busy",    busy,     1'b0);
        check("rst_keep",    pe_keep,  1'b1);
        check("rst_pe_rstn", pe_rst_n, 1'b0);
        check("rst_ready",   s_ready,  1'b0);
        rst_n = 1'b1;
        step();
        step();

        // 1: K=1, a=1.0 b=2.0, back-to-back
        r0 = ren_seen; k0 = keep_run; p0 = prst_low;
        start_tile(8'd1);
        feed(1, 16'h0200, 16'h0400, 16'h0000, -1, 0, -1);
        check("t1_first_add", pe_add_number, 4'd0);
        check("t1_first_a",   pe_data_in_1,  16'h0200);
        check("t1_first_b",   pe_data_in_2,  16'h0400);
        check("t1_first_ren", pe_rounder_en, 1'b1);
        feed(7, 16'h0200, 16'h0400, 16'h0000, -1, 0, -1);
        check("t1_last_add",  pe_add_number, 4'd7);
        check("t1_last_ren",  pe_rounder_en, 1'b1);
        drain_finish(3);
        check("t1_len",      done_cyc - t0,     14);
        check("t1_ren_cnt",  ren_seen - r0,     8);
        check("t1_stalls",   keep_run - k0,     0);
        check("t1_prst_low", prst_low - p0,     1);

        // 2: K=3, two-cycle stall before beat 5
        r0 = ren_seen; k0 = keep_run;
        start_tile(8'd3);
        feed(24, 16'h0100, 16'h0F00, 16'h0011, 5, 2, -1);
        drain_finish(3);
        check("t2_len",     done_cyc - t0, 32);
        check("t2_ren_cnt", ren_seen - r0, 8);
        check("t2_stalls",  keep_run - k0, 2);

        // 3: cfg_k=0 acts as one pass; rounder_valid outside DRAIN ignored
        r0 = ren_seen;
        start_tile(8'd0);
        pe_rounder_valid = 1'b1;
        feed(8, 16'hFE00, 16'h0080, 16'h0003, -1, 0, -1);
        pe_rounder_valid = 1'b0;
        drain_finish(3);
        check("t3_len",     done_cyc - t0, 14);
        check("t3_ren_cnt", ren_seen - r0, 8);

        // 4: start during RUN is ignored
        r0 = ren_seen;
        start_tile(8'd1);
        feed(8, 16'h0A0A, 16'h0505, 16'h0101, -1, 0, 3);
        drain_finish(3);
        check("t4_len",     done_cyc - t0, 14);
        check("t4_ren_cnt", ren_seen - r0, 8);

        // 5: reset mid-tile, then a clean tile
        start_tile(8'd2);
        feed(4, 16'h1234, 16'h4321, 16'h0001, -1, 0, -1);
        rst_n = 1'b0;
        step();
        check("t5_busy",  busy,     1'b0);
        check("t5_keep",  pe_keep,  1'b1);
        check("t5_prstn", pe_rst_n, 1'b0);
        check("t5_done",  done,     1'b0);
        rst_n = 1'b1;
        step();
        step();
        start_tile(8'd1);
        feed(8, 16'h0200, 16'h0400, 16'h0001, -1, 0, -1);
        drain_finish(3);
        check("t5_len", done_cyc - t0, 14);

`ifdef PE_FEED_TIMEOUT_EN
        // 6: PE never answers; watchdog forces clear and raises err
        start_tile(8'd1);
        feed(8, 16'h0300, 16'h0100, 16'h0000, -1, 0, -1);
        wait_phase(0, 40);
        step();
        check("t6_err",  err,           1'b1);
        check("t6_len",  done_cyc - t0, 26);
        start_tile(8'd1);
        check("t6_err_clr", err, 1'b0);
        feed(8, 16'h0300, 16'h0100, 16'h0000, -1, 0, -1);
        drain_finish(3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
